// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the CPU data-memory port: access sizes, MMIO offsets,
// responder FSM states and the lane helpers used by the load/store path.
package data_mem_responder_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_X = 2'b11
   } size_t;

   localparam logic [31:0] MMIO_BASE_DEF = 32'h8000_0000;
   localparam logic [31:0] LED_OFF       = 32'h0000_0000;
   localparam logic [31:0] SW_OFF        = 32'h0000_0004;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      RD_WAIT = 2'b01,
      RESP    = 2'b10
   } state_t;

   function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] lane);
      logic [3:0] be;
      case (sz)
         SZ_B:    be = 4'b0001 << lane;
         SZ_H:    be = lane[1] ? 4'b1100 : 4'b0011;
         SZ_W:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   // Pick the addressed byte/half out of a full word and sign- or zero-extend it.
   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] sz, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (sz)
         SZ_B:    r = uns ? {24'b0, b} : {{24{b[7]}}, b};
         SZ_H:    r = uns ? {16'b0, h} : {{16{h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/data_mem_responder_sync.sv
// Two-flop synchronizer bringing the asynchronous board switches into the clk domain.
module sync_2ff #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder for the CPU MEM stage: word-wide data RAM plus a small
// MMIO window (LED register, switch readback) behind a req/ack handshake.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [1:0]  size,
   input  logic        ld_unsigned,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ack,
   output logic        err,
   input  logic [15:0] sw,
   output logic [15:0] led
);

   localparam int AW = $clog2(DEPTH_WORDS);

   state_t      state, next_state;
   logic [15:0] sw_sync;
   logic [31:0] led_reg;
   logic [31:0] ram [DEPTH_WORDS];
   logic [31:0] ram_q;

   logic [1:0]  cap_lane;
   logic [1:0]  cap_size;
   logic        cap_unsigned;
   logic        cap_is_led;
   logic        cap_is_sw;

   logic        in_ram, is_led, is_sw, misaligned, req_err, accept, do_write;
   logic [3:0]  be;
   logic [31:0] wdata_rep;
   logic [31:0] rd_word;

   sync_2ff #(.WIDTH(16)) u_sw_sync (
      .clk (clk),
      .rst (rst),
      .d   (sw),
      .q   (sw_sync)
   );

   // Decode the request as presented; errors are decided before anything is touched.
   always_comb begin
      in_ram     = addr < 32'(DEPTH_WORDS * 4);
      is_led     = addr == (MMIO_BASE + LED_OFF);
      is_sw      = addr == (MMIO_BASE + SW_OFF);
      misaligned = (size == SZ_H && addr[0]) || (size == SZ_W && addr[1:0] != 2'b00);
      req_err    = (size == SZ_X) || misaligned || !(in_ram || is_led || (is_sw && !we));
      accept     = (state == IDLE) && req;
      do_write   = accept && we && !req_err;
      be         = byte_en(size, addr[1:0]);
      case (size)
         SZ_B:    wdata_rep = {4{wdata[7:0]}};
         SZ_H:    wdata_rep = {2{wdata[15:0]}};
         default: wdata_rep = wdata;
      endcase
      rd_word = cap_is_sw ? {16'b0, sw_sync} : (cap_is_led ? led_reg : ram_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (req) next_state = (we || req_err) ? RESP : RD_WAIT;
         RD_WAIT: next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Stores land on the accept edge so a load issued right after ack sees them.
   always_ff @(posedge clk) begin
      if (do_write && in_ram) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) ram[addr[AW+1:2]][8*i +: 8] <= wdata_rep[8*i +: 8];
         end
      end
      ram_q <= ram[addr[AW+1:2]];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led_reg      <= '0;
         cap_lane     <= '0;
         cap_size     <= '0;
         cap_unsigned <= 1'b0;
         cap_is_led   <= 1'b0;
         cap_is_sw    <= 1'b0;
         ack          <= 1'b0;
         err          <= 1'b0;
         rdata        <= '0;
      end else begin
         ack   <= 1'b0;
         err   <= 1'b0;
         rdata <= '0;
         if (accept) begin
            cap_lane     <= addr[1:0];
            cap_size     <= size;
            cap_unsigned <= ld_unsigned;
            cap_is_led   <= is_led;
            cap_is_sw    <= is_sw;
            if (we || req_err) begin
               ack <= 1'b1;
               err <= req_err;
            end
         end
         if (do_write && is_led) begin
            for (int i = 0; i < 4; i++) begin
               if (be[i]) led_reg[8*i +: 8] <= wdata_rep[8*i +: 8];
            end
         end
         if (state == RD_WAIT) begin
            ack   <= 1'b1;
            rdata <= load_extend(rd_word, cap_lane, cap_size, cap_unsigned);
         end
      end
   end

   assign led = led_reg[15:0];

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: each access pushes its expected response
// to a scoreboard queue that is popped and compared when ack arrives.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [31:0] addr = '0;
   logic [1:0]  size = 2'b00;
   logic        ld_unsigned = 1'b0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        ack;
   logic        err;
   logic [15:0] sw = '0;
   logic [15:0] led;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad = 0;

   data_mem_responder dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .we          (we),
      .addr        (addr),
      .size        (size),
      .ld_unsigned (ld_unsigned),
      .wdata       (wdata),
      .rdata       (rdata),
      .ack         (ack),
      .err         (err),
      .sw          (sw),
      .led         (led)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Drive one request at a falling edge and record the response it should produce.
   task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [1:0] sz,
                                input logic uns, input logic [31:0] d,
                                input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
      exp_t e;
      @(negedge clk);
      req = 1'b1; we = w; addr = a; size = sz; ld_unsigned = uns; wdata = d;
      e.rdata = exp_rd; e.err = exp_err; e.lat = exp_lat;
      sbq.push_back(e);
   endtask

   // Wait (bounded) for ack, then compare against the oldest scoreboard entry.
   task automatic checkOutput(input string tag);
      exp_t e;
      int   cycles = 0;
      bit   got = 0;
      e = sbq.pop_front();
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         cycles++;
         if (ack) begin
            got = 1;
            break;
         end
      end
      req = 1'b0;
      checkVal({tag, "_ack"}, {31'b0, got}, 32'd1);
      if (got) begin
         checkVal({tag, "_lat"}, cycles, e.lat);
         checkVal({tag, "_err"}, {31'b0, err}, {31'b0, e.err});
         checkVal({tag, "_rdata"}, rdata, e.rdata);
         @(posedge clk); #1;
         checkVal({tag, "_ackdrop"}, {31'b0, ack}, 32'd0);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      checkVal("rst_ack", {31'b0, ack}, 32'd0);
      checkVal("rst_err", {31'b0, err}, 32'd0);
      checkVal("rst_rdata", rdata, 32'd0);
      checkVal("rst_led", {16'b0, led}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // LED register word store and readback
      applyStimulus(1'b1, 32'h8000_0000, 2'b10, 1'b0, 32'd123, 32'd0, 1'b0, 1);
      checkOutput("sw_led");
      checkVal("led_123", {16'b0, led}, 32'd123);
      applyStimulus(1'b0, 32'h8000_0000, 2'b10, 1'b0, 32'd0, 32'd123, 1'b0, 2);
      checkOutput("lw_led");

      // Halfword store/load with sign and zero extension
      applyStimulus(1'b1, 32'h8000_0000, 2'b01, 1'b0, 32'd532, 32'd0, 1'b0, 1);
      checkOutput("sh_532");
      applyStimulus(1'b0, 32'h8000_0000, 2'b01, 1'b0, 32'd0, 32'd532, 1'b0, 2);
      checkOutput("lh_532");
      applyStimulus(1'b1, 32'h8000_0000, 2'b01, 1'b0, 32'hFFFF_8001, 32'd0, 1'b0, 1);
      checkOutput("sh_8001");
      applyStimulus(1'b0, 32'h8000_0000, 2'b01, 1'b0, 32'd0, 32'hFFFF_8001, 1'b0, 2);
      checkOutput("lh_8001");
      applyStimulus(1'b0, 32'h8000_0000, 2'b01, 1'b1, 32'd0, 32'h0000_8001, 1'b0, 2);
      checkOutput("lhu_8001");

      // RAM word, byte merge and byte loads
      applyStimulus(1'b1, 32'h0000_0010, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'd0, 1'b0, 1);
      checkOutput("sw_ram");
      applyStimulus(1'b1, 32'h0000_0012, 2'b00, 1'b0, 32'h0000_0055, 32'd0, 1'b0, 1);
      checkOutput("sb_ram");
      applyStimulus(1'b0, 32'h0000_0010, 2'b10, 1'b1, 32'd0, 32'hDE55_BEEF, 1'b0, 2);
      checkOutput("lw_ram");
      applyStimulus(1'b0, 32'h0000_0013, 2'b00, 1'b0, 32'd0, 32'hFFFF_FFDE, 1'b0, 2);
      checkOutput("lb_ram");
      applyStimulus(1'b0, 32'h0000_0013, 2'b00, 1'b1, 32'd0, 32'h0000_00DE, 1'b0, 2);
      checkOutput("lbu_ram");
      applyStimulus(1'b0, 32'h0000_0012, 2'b01, 1'b0, 32'd0, 32'hFFFF_DE55, 1'b0, 2);
      checkOutput("lh_hi");

      // Error responses leave RAM and LEDs untouched
      applyStimulus(1'b0, 32'h0000_0011, 2'b10, 1'b0, 32'd0, 32'd0, 1'b1, 1);
      checkOutput("err_lw_mis");
      applyStimulus(1'b1, 32'h0000_0013, 2'b01, 1'b0, 32'h0000_1234, 32'd0, 1'b1, 1);
      checkOutput("err_sh_mis");
      applyStimulus(1'b1, 32'h0000_0010, 2'b11, 1'b0, 32'h1111_1111, 32'd0, 1'b1, 1);
      checkOutput("err_size");
      applyStimulus(1'b0, 32'h4000_0000, 2'b10, 1'b0, 32'd0, 32'd0, 1'b1, 1);
      checkOutput("err_range");
      applyStimulus(1'b1, 32'h8000_0004, 2'b10, 1'b0, 32'h0000_FFFF, 32'd0, 1'b1, 1);
      checkOutput("err_ro");
      applyStimulus(1'b1, 32'h8000_0008, 2'b10, 1'b0, 32'h0000_FFFF, 32'd0, 1'b1, 1);
      checkOutput("err_mmio_hole");
      checkVal("led_kept", {16'b0, led}, 32'h0000_8001);
      applyStimulus(1'b0, 32'h0000_0010, 2'b10, 1'b0, 32'd0, 32'hDE55_BEEF, 1'b0, 2);
      checkOutput("ram_kept");

      // Highest RAM word is still in range
      applyStimulus(1'b1, 32'h0000_0FFC, 2'b10, 1'b0, 32'h0BAD_F00D, 32'd0, 1'b0, 1);
      checkOutput("sw_top");
      applyStimulus(1'b0, 32'h0000_0FFC, 2'b10, 1'b0, 32'd0, 32'h0BAD_F00D, 1'b0, 2);
      checkOutput("lw_top");
      applyStimulus(1'b0, 32'h0000_1000, 2'b10, 1'b0, 32'd0, 32'd0, 1'b1, 1);
      checkOutput("err_past_top");

      // Switch readback through the synchronizer
      #3 sw = 16'hA5C3;
      repeat (3) @(posedge clk);
      applyStimulus(1'b0, 32'h8000_0004, 2'b10, 1'b0, 32'd0, 32'h0000_A5C3, 1'b0, 2);
      checkOutput("lw_sw");

      // Reset during RD_WAIT aborts the load
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 32'h0000_0010; size = 2'b10; ld_unsigned = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      req = 1'b0;
      begin
         bit saw_ack = 0;
         for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ack) saw_ack = 1;
         end
         checkVal("rst_abort_ack", {31'b0, saw_ack}, 32'd0);
      end
      checkVal("rst_abort_led", {16'b0, led}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b0, 32'h0000_0010, 2'b10, 1'b0, 32'd0, 32'hDE55_BEEF, 1'b0, 2);
      checkOutput("ram_after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
